// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three handshakes around the shared unified-memory port:
//   fetch side : if_req/if_addr/if_flush in, if_gnt/if_rvalid/if_rdata out
//   data side  : d_req/d_we/d_addr/d_wdata/d_be in, d_gnt/d_rvalid/d_rdata out
//   memory side: mem_req/mem_we/mem_addr/mem_wdata/mem_be out, mem_rdata in
// Modport "slave" is the arbiter's view; modport "master" is the view of the
// environment that owns the requesters and the memory model.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  // Fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  // Data (load/store) requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // Single-port memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch and
// the load/store stage. One access is granted per cycle; the data side wins
// unless fetch has been passed over MAX_D_STREAK times in a row. Every read is
// tagged with its source in a MEM_LAT-deep pipeline so the returning word is
// routed to the requester that issued it.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   reset  - synchronous, active-high
//   bus    - mem_port_arbiter_if.slave (fetch, data and memory handshakes)
//
// Parameters:
//   MEM_LAT      - memory read latency in cycles (1..4)
//   MAX_D_STREAK - consecutive data grants allowed while fetch waits (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  // Arbitration state
  logic [3:0]         streak_r;

  // Tag pipeline: stage MEM_LAT-1 is the entry whose data is on mem_rdata now
  logic [MEM_LAT-1:0] tag_valid_r;
  logic [MEM_LAT-1:0] tag_src_if_r;

  // Last delivered word per requester
  logic [31:0]        if_rdata_r;
  logic [31:0]        d_rdata_r;

  logic               fetch_first_s;
  logic               if_gnt_s;
  logic               d_gnt_s;
  logic               new_valid_s;
  logic               exit_valid_s;
  logic               exit_if_s;
  logic               if_rvalid_s;
  logic               d_rvalid_s;

  // Grant selection: data wins unless the fetch side has hit its streak limit
  always_comb begin
    if_gnt_s      = 1'b0;
    d_gnt_s       = 1'b0;
    fetch_first_s = bus.if_req && (streak_r == STREAK_MAX);
    if (reset) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (bus.d_req && !fetch_first_s) begin
      d_gnt_s = 1'b1;
    end else if (bus.if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
  end

  // Memory port mirrors the granted request in the same cycle
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0000_0000;
    bus.mem_wdata = 32'h0000_0000;
    bus.mem_be    = 4'hF;
    if (d_gnt_s) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_we ? bus.d_be : 4'hF;
    end else if (if_gnt_s) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = bus.if_addr;
      bus.mem_wdata = 32'h0000_0000;
      bus.mem_be    = 4'hF;
    end else begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0000_0000;
      bus.mem_wdata = 32'h0000_0000;
      bus.mem_be    = 4'hF;
    end
  end

  // A flushed fetch never becomes a live tag, even when granted in the flush cycle.
  assign new_valid_s  = (if_gnt_s && !bus.if_flush) || (d_gnt_s && !bus.d_we);
  assign exit_valid_s = tag_valid_r[MEM_LAT-1];
  assign exit_if_s    = tag_src_if_r[MEM_LAT-1];

  // A fetch response exiting in the flush cycle is suppressed here; stores
  // occupy a slot with valid=0 and so never disturb routing.
  assign if_rvalid_s  = !reset && exit_valid_s && exit_if_s && !bus.if_flush;
  assign d_rvalid_s   = !reset && exit_valid_s && !exit_if_s;

  assign bus.if_gnt    = if_gnt_s;
  assign bus.d_gnt     = d_gnt_s;
  assign bus.if_rvalid = if_rvalid_s;
  assign bus.d_rvalid  = d_rvalid_s;
  assign bus.if_rdata  = if_rvalid_s ? bus.mem_rdata : if_rdata_r;
  assign bus.d_rdata   = d_rvalid_s  ? bus.mem_rdata : d_rdata_r;

  // Starvation counter: counts data grants that passed over a waiting fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_r <= 4'd0;
    end else if (!bus.if_req || if_gnt_s) begin
      streak_r <= 4'd0;
    end else if (d_gnt_s && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + 4'd1;
    end else begin
      streak_r <= streak_r;
    end
  end

  // Tag shift register; a flush kills every fetch-tagged entry as it moves
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_r  <= {MEM_LAT{1'b0}};
      tag_src_if_r <= {MEM_LAT{1'b0}};
    end else begin
      tag_valid_r[0]  <= new_valid_s;
      tag_src_if_r[0] <= if_gnt_s;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_valid_r[i]  <= tag_valid_r[i-1] && !(bus.if_flush && tag_src_if_r[i-1]);
        tag_src_if_r[i] <= tag_src_if_r[i-1];
      end
    end
  end

  // Hold the last delivered word of each requester between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_r <= 32'h0000_0000;
      d_rdata_r  <= 32'h0000_0000;
    end else begin
      if (if_rvalid_s) begin
        if_rdata_r <= bus.mem_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if (d_rvalid_s) begin
        d_rdata_r <= bus.mem_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch stage and its load/store (MEM) stage.
- Arbitrates one access per cycle; data side wins by default; a streak limit bounds fetch starvation.
- Tags every in-flight read and routes each returning word to the requester that issued it.
- Sits between the riscv_pipeline fetch/MEM stages and the memory model.

Parameters:
- MEM_LAT, 2, memory read latency in cycles; legal range 1..4.
- MAX_D_STREAK, 3, max consecutive data grants while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until granted.
- if_addr  in  32  fetch byte address, word aligned.
- if_flush  in  1  discard all in-flight fetch responses (redirect).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data.
- mem_req  out  1  memory access issued this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; forced to 4'hF on reads.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after a read issue.

Behaviour:
- Grant is combinational from current requests and state. At most one of if_gnt/d_gnt is high per cycle. mem_* mirror the granted request in the same cycle. With no grant: mem_req=0 and mem_we=0.
- Priority: d_req wins unless if_req=1 and streak==MAX_D_STREAK, in which case fetch wins.
- streak counter (4 bits):
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, and on any cycle with if_req=0.
  - Saturates at MAX_D_STREAK.
- Tag pipeline: MEM_LAT-deep shift register of {valid, src}.
  - A read granted in cycle T enters with valid=1 and src = IF or D. Stores enter valid=0.
  - The entry exits in cycle T+MEM_LAT.
  - On exit with valid=1: raise the matching rvalid for exactly one cycle and drive rdata = mem_rdata.
  - rdata of the non-selected requester holds its last value.
- Responses return in issue order; back-to-back reads yield rvalid on consecutive cycles.
- if_flush=1 in cycle T:
  - Clears valid on every IF-tagged entry, including a fetch granted in cycle T.
  - A fetch rvalid would otherwise appear in T; it is suppressed.
  - D-tagged entries are unaffected.
  - The if_gnt handshake itself is still honoured.
- Simultaneous events:
  - d_req and if_req with streak < MAX_D_STREAK: d_gnt=1.
  - Store grant with a read response exiting the pipeline: both proceed. A store does not block response routing.
- Reset is synchronous:
  - In a cycle with reset=1: if_gnt=d_gnt=0, mem_req=0, mem_we=0, if_rvalid=d_rvalid=0.
  - On the reset edge: if_rdata=d_rdata=0, streak=0, all tag valids=0.
  - Reset mid-operation drops every in-flight response; no rvalid for them after reset deasserts.
- Read and write to the same address in consecutive cycles need no ordering logic; memory order equals grant order.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → all gnt/rvalid/mem_req=0, rdata=0; no spurious rvalid for 8 cycles.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0 in cycle 3 → if_gnt=1 and mem_addr=0 in cycle 3; memory returns 0xDEADBEEF → if_rvalid=1, if_rdata=0xDEADBEEF in cycle 5 only.
- Contention/starvation, MAX_D_STREAK=3: if_req and d_req held high with loads to 0x4, 0x8, 0xC, 0x10 → d_gnt for 3 cycles, if_gnt in cycle 4, then d_gnt; the 4 rvalids return in grant order.
- Store: d_req=1, d_we=1, d_addr=0xC, d_wdata=0xFEDCBA98, d_be=4'hF → mem_we=1 with those values in the grant cycle; no d_rvalid ever follows. A later load from 0xC returns 0xFEDCBA98.
- Flush: fetches granted in cycles 10 and 11, load granted in cycle 12, if_flush=1 in cycle 11 → no if_rvalid in cycles 12/13; d_rvalid=1 in cycle 14.
- Reset mid-flight: load granted in cycle 20, reset=1 in cycle 21 → d_rvalid stays 0 in cycle 22; streak=0 after reset.
